// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory subsystem: access sizes,
// controller states and the alignment rule.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // An access is rejected when it is misaligned for its size or uses the
  // reserved size encoding.
  function automatic logic access_err(input logic [1:0] size,
                                      input logic [1:0] byte_off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return byte_off[0];
      SZ_WORD: return byte_off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte-enables and lane data, and load
// extraction with sign or zero extension.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  st_mask,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic [31:0] rd_shifted;

  // Replicating the narrow store data into every lane means only the mask
  // has to depend on the byte offset.
  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    st_mask = 4'b0000;
    st_word = st_data;
    case (size)
      SZ_BYTE: begin
        st_mask = 4'b0001 << byte_off;
        st_word = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_mask = byte_off[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_data[15:0]}};
      end
      SZ_WORD: st_mask = 4'b1111;
      default: st_mask = 4'b0000;
    endcase
  end

  always_comb begin
    rd_shifted = rd_word >> {byte_off, 3'b000};
    case (size)
      SZ_BYTE: ld_data = {{24{sign_ext & rd_shifted[7]}}, rd_shifted[7:0]};
      SZ_HALF: ld_data = {{16{sign_ext & rd_shifted[15]}}, rd_shifted[15:0]};
      default: ld_data = rd_word;
    endcase
  end

endmodule

// File: rtl/mips_data_mem_ctrl.sv
// Data memory for the MIPS core: req/ready handshake with configurable wait
// states, byte/half/word access and a resettable storage array.
module mips_data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [1:0]     size_q, size_d;
  logic           sext_q, sext_d;
  logic [AW+1:0]  addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    r_data_q, r_data_d;
  logic           ready_q, ready_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;

  logic [31:0]    mem_q [DEPTH_WORDS];

  logic           acc_we, acc_sext, acc_err;
  logic [1:0]     acc_size;
  logic [AW+1:0]  acc_addr;
  logic [31:0]    acc_wdata;
  logic           enter_done, mem_wr;
  logic [AW-1:0]  mem_idx;
  logic [31:0]    rd_word, wr_word, st_word, ld_data;
  logic [3:0]     st_mask;

  logic           unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  // In IDLE the access being decided is the one on the inputs; once accepted
  // it is the latched copy, so a zero-wait access can commit on its accept edge.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = we;
      acc_size  = size;
      acc_sext  = sign_ext;
      acc_addr  = addr[AW+1:0];
      acc_wdata = w_data;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_sext  = sext_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_err = access_err(acc_size, acc_addr[1:0]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          addr_d  = addr[AW+1:0];
          wdata_d = w_data;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_LOAD == 4'd0 || acc_err) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  mem_lane_align u_align (
    .size     (acc_size),
    .sign_ext (acc_sext),
    .byte_off (acc_addr[1:0]),
    .st_data  (acc_wdata),
    .rd_word  (rd_word),
    .st_mask  (st_mask),
    .st_word  (st_word),
    .ld_data  (ld_data)
  );

  always_comb begin
    enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    mem_idx    = acc_addr[AW+1:2];
    rd_word    = mem_q[mem_idx];
    mem_wr     = enter_done && acc_we && !acc_err;
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = st_mask[i] ? st_word[8*i +: 8] : rd_word[8*i +: 8];
    end
    r_data_d = (enter_done && !acc_we && !acc_err) ? ld_data : r_data_q;
    ready_d  = (state_d == ST_DONE);
    err_d    = ready_d && acc_err;
    busy_d   = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      sext_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      r_data_q <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      sext_q   <= sext_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      r_data_q <= r_data_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // NOTE: the storage array must come out of reset all-zero, so it is reset
  // like any other flop; this forbids mapping it onto an unresettable RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_wr) begin
      mem_q[mem_idx] <= wr_word;
    end
  end

  assign r_data = r_data_q;
  assign ready  = ready_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mips_data_mem_ctrl.sv
// Directed bench for mips_data_mem_ctrl: one instance with two wait states
// and one with none, sharing clock, reset and access fields.
module tb_mips_data_mem_ctrl;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, w_data;
  logic [31:0] r_data0, r_data1;
  logic        ready0, ready1, err0, err1, busy0, busy1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut_w2 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .w_data(w_data),
    .r_data(r_data0), .ready(ready0), .err(err0), .busy(busy0)
  );

  mips_data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .w_data(w_data),
    .r_data(r_data1), .ready(ready1), .err(err1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one access and wait (bounded) for ready; lat counts cycles from
  // the accept edge, 0 means no ready was seen.
  task automatic run(input bit sel, input logic w, input logic [1:0] sz,
                     input logic sx, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic e, output logic bz_ok);
    @(negedge clk);
    we = w; size = sz; sign_ext = sx; addr = a; w_data = d;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    lat = 0; e = 1'b0; bz_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!(sel ? busy1 : busy0)) bz_ok = 1'b0;
      if (sel ? ready1 : ready0) begin
        lat = k;
        e   = sel ? err1 : err0;
        break;
      end
    end
  endtask

  task automatic store_chk(input string tag, input bit sel, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d,
                           input int exp_lat, input logic exp_err);
    int lat; logic e, bz;
    run(sel, 1'b1, sz, 1'b0, a, d, lat, e, bz);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_busy"}, {31'd0, bz}, 32'd1);
  endtask

  task automatic load_chk(input string tag, input bit sel, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a,
                          input logic [31:0] exp_data, input int exp_lat,
                          input logic exp_err);
    int lat; logic e, bz;
    run(sel, 1'b0, sz, sx, a, 32'h0, lat, e, bz);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_busy"}, {31'd0, bz}, 32'd1);
    check({tag, "_data"}, sel ? r_data1 : r_data0, exp_data);
  endtask

  initial begin
    int rdy_cnt;
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0; size = SZ_BYTE;
    sign_ext = 1'b0; addr = '0; w_data = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", r_data0, 32'h0);
    check("rst_ready", {31'd0, ready0}, 32'd0);
    check("rst_err",   {31'd0, err0},   32'd0);
    check("rst_busy",  {31'd0, busy0},  32'd0);
    reset = 1'b1;

    // Basic word store/load and sub-word loads.
    store_chk("st_w10", 0, SZ_WORD, 32'h10, 32'hDEADBEEF, 3, 1'b0);
    @(negedge clk);
    check("post_busy",  {31'd0, busy0},  32'd0);
    check("post_ready", {31'd0, ready0}, 32'd0);
    load_chk("ld_w10",   0, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 3, 1'b0);
    load_chk("ld_b11_s", 0, SZ_BYTE, 1'b1, 32'h11, 32'hFFFFFFBE, 3, 1'b0);
    load_chk("ld_h12_z", 0, SZ_HALF, 1'b0, 32'h12, 32'h0000DEAD, 3, 1'b0);

    // Byte store preserves the other lanes.
    store_chk("st_b13", 0, SZ_BYTE, 32'h13, 32'h00000055, 3, 1'b0);
    load_chk("ld_w10b", 0, SZ_WORD, 1'b0, 32'h10, 32'h55ADBEEF, 3, 1'b0);

    // Rejected accesses: fast completion, no memory or r_data change.
    store_chk("st_h11_bad", 0, SZ_HALF, 32'h11, 32'h00001234, 1, 1'b1);
    check("bad_st_rdata", r_data0, 32'h55ADBEEF);
    load_chk("ld_rsvd", 0, SZ_RSVD, 1'b0, 32'h10, 32'h55ADBEEF, 1, 1'b1);
    load_chk("ld_w10c", 0, SZ_WORD, 1'b0, 32'h10, 32'h55ADBEEF, 3, 1'b0);
    load_chk("ld_h10_s", 0, SZ_HALF, 1'b1, 32'h10, 32'hFFFFBEEF, 3, 1'b0);
    load_chk("ld_b13_s", 0, SZ_BYTE, 1'b1, 32'h13, 32'h00000055, 3, 1'b0);
    load_chk("ld_w12_bad", 0, SZ_WORD, 1'b0, 32'h12, 32'h00000055, 1, 1'b1);

    // Address wrap on the word index.
    store_chk("st_w400", 0, SZ_WORD, 32'h400, 32'h12345678, 3, 1'b0);
    load_chk("ld_w0_wrap", 0, SZ_WORD, 1'b0, 32'h0, 32'h12345678, 3, 1'b0);

    // A request raised while busy is dropped.
    @(negedge clk);
    we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h0; req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    rdy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready0) rdy_cnt++;
      if (k == 0) begin
        we = 1'b1; addr = 32'h0; w_data = 32'hFFFFFFFF; req0 = 1'b1;
      end else begin
        req0 = 1'b0;
      end
    end
    check("busy_req_ready_cnt", 32'(rdy_cnt), 32'd1);
    load_chk("ld_w0_kept", 0, SZ_WORD, 1'b0, 32'h0, 32'h12345678, 3, 1'b0);

    // Reset in the middle of a store aborts it and clears memory.
    @(negedge clk);
    we = 1'b1; size = SZ_WORD; addr = 32'h20; w_data = 32'hAAAAAAAA; req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(negedge clk);
    check("mid_busy", {31'd0, busy0}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_rdata", r_data0, 32'h0);
    check("arst_ready", {31'd0, ready0}, 32'd0);
    check("arst_err",   {31'd0, err0},   32'd0);
    check("arst_busy",  {31'd0, busy0},  32'd0);
    @(negedge clk);
    reset = 1'b1;
    load_chk("ld_w20_clr", 0, SZ_WORD, 1'b0, 32'h20, 32'h00000000, 3, 1'b0);
    load_chk("ld_w10_clr", 0, SZ_WORD, 1'b0, 32'h10, 32'h00000000, 3, 1'b0);

    // Zero wait states: ready one cycle after accept.
    store_chk("z_st_w8", 1, SZ_WORD, 32'h8, 32'hCAFEF00D, 1, 1'b0);
    load_chk("z_ld_w8", 1, SZ_WORD, 1'b0, 32'h8, 32'hCAFEF00D, 1, 1'b0);
    store_chk("z_st_b9", 1, SZ_BYTE, 32'h9, 32'h00000077, 1, 1'b0);
    load_chk("z_ld_w8b", 1, SZ_WORD, 1'b0, 32'h8, 32'hCAFE770D, 1, 1'b0);
    load_chk("z_ld_h9_bad", 1, SZ_HALF, 1'b0, 32'h9, 32'hCAFE770D, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
